// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes and
// the registered request bundle.
package load_store_unit_pkg;

  localparam int LSU_RAM_AW = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic        err;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] bword;
  logic [31:0] hword;
  logic [31:0] mask;
  logic [31:0] ins;

  assign bsh   = {lane, 3'b000};
  assign hsh   = {lane[1], 4'b0000};
  assign bword = rdata >> bsh;
  assign hword = rdata >> hsh;

  always_comb begin
    ld_data = rdata;
    mask    = 32'hffff_ffff;
    ins     = wdata;
    unique case (size)
      SZ_BYTE: begin
        ld_data = {{24{sgn & bword[7]}}, bword[7:0]};
        mask    = 32'h0000_00ff << bsh;
        ins     = wdata << bsh;
      end
      SZ_HALF: begin
        ld_data = {{16{sgn & hword[15]}}, hword[15:0]};
        mask    = 32'h0000_ffff << hsh;
        ins     = wdata << hsh;
      end
      default: ;
    endcase
  end

  assign st_data = (rdata & ~mask) | (ins & mask);

endmodule

// File: rtl/load_store_unit.sv
// Single-port RAM load/store unit; define LSU_RMW_EN to enable
// read-modify-write sub-word stores (otherwise they are rejected).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RAM_AW = LSU_RAM_AW,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  lsu_state_t        state;
  lsu_state_t        state_d;
  lsu_req_t          req_q;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;
  logic              accept;
  logic              err_in;
  logic              bad_size;
  logic              bad_align;
  logic              bad_range;
  logic              sub_store;
  logic              wr_direct;

  assign accept = req_valid & req_ready;

  assign bad_size  = req_size == 2'b11;
  assign bad_align = (req_size == SZ_HALF && req_addr[0])
                   | (req_size == SZ_WORD && |req_addr[1:0]);
  assign bad_range = |req_addr[31:RAM_AW+2];
  assign sub_store = req_we & (req_size != SZ_WORD);

`ifdef LSU_RMW_EN
  assign err_in = bad_size | bad_align | bad_range;
`else
  assign err_in = bad_size | bad_align | bad_range | sub_store;
`endif

  assign wr_direct = ~err_in & req_we & ~sub_store;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            err_in:    state_d = RESP;
            wr_direct: state_d = WRITE;
            default:   state_d = READ;
          endcase
        end
      end
`ifdef LSU_RMW_EN
      READ:    state_d = req_q.we ? WRITE : RESP;
`else
      READ:    state_d = RESP;
`endif
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        req_q <= '{
          we:    req_we,
          size:  req_size,
          sgn:   req_signed,
          lane:  req_addr[1:0],
          err:   err_in,
          wdata: req_wdata
        };
        addr_q  <= req_addr[RAM_AW+1:2];
        rdata_q <= '0;
        if (req_we) wdata_q <= req_wdata;
      end
      if (state == READ && !req_q.we) rdata_q <= ld_data;
`ifdef LSU_RMW_EN
      // merged word is registered so ram_wdata is stable in WRITE
      if (state == READ && req_q.we) wdata_q <= st_data;
`endif
    end
  end

`ifndef LSU_RMW_EN
  logic unused_merge;
  assign unused_merge = ^{st_data, req_q.wdata};
`endif

  lsu_lane_align u_align (
    .size    (req_q.size),
    .lane    (req_q.lane),
    .sgn     (req_q.sgn),
    .rdata   (ram_rdata),
    .wdata   (req_q.wdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  assign req_ready = state == IDLE;
  assign ram_en    = (state == READ) | (state == WRITE);
  assign ram_rw    = state != WRITE;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rsp_valid = state == RESP;
  assign rsp_err   = rsp_valid & req_q.err;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural RAM;
// expectations follow LSU_RMW_EN when it is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic        ram_rw;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RAM_AW(16), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_en     (ram_en),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  assign ram_rdata = (ram_en && ram_rw) ? mem[ram_addr] : 32'h0;

  always @(posedge clk)
    if (ram_en && !ram_rw) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          lat;
  int          en_cnt;
  logic [31:0] rd;
  logic        er;
  logic        rdy1;
  logic [15:0] ea;
  logic [31:0] ewd;

  task automatic xact(input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat    = 0;
    en_cnt = 0;
    rd     = 32'hx;
    er     = 1'bx;
    ea     = 16'h0;
    ewd    = 32'h0;
    rdy1   = 1'bx;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) rdy1 = req_ready;
      if (ram_en) begin
        en_cnt++;
        ea = ram_addr;
        if (!ram_rw) ewd = ram_wdata;
      end
      if (rsp_valid) begin
        lat = n;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] exp);
    xact(1'b0, sz, sg, a, 32'h0);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"}, {31'b0, er}, 32'd0);
  endtask

  task automatic reject(input string tag, input logic we,
                        input logic [1:0] sz, input logic [31:0] a);
    xact(we, sz, 1'b0, a, 32'h5555_aaaa);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, {31'b0, er}, 32'd1);
    chk({tag, "_data"}, rd, 32'h0);
    chk({tag, "_ramen"}, 32'(en_cnt), 32'd0);
  endtask

  initial begin
    logic seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rspv", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsperr", {31'b0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ramen", {31'b0, ram_en}, 32'd0);
    chk("rst_ramrw", {31'b0, ram_rw}, 32'd1);
    chk("rst_ramaddr", {16'b0, ram_addr}, 32'h0);
    chk("rst_ramwd", ram_wdata, 32'h0);
    rst = 1'b0;

    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hdead_beef);
    chk("stw_lat", 32'(lat), 32'd2);
    chk("stw_err", {31'b0, er}, 32'd0);
    chk("stw_ramen", 32'(en_cnt), 32'd1);
    chk("stw_addr", {16'b0, ea}, 32'h40);
    chk("stw_wdata", ewd, 32'hdead_beef);
    chk("stw_busy", {31'b0, rdy1}, 32'd0);
    chk("stw_mem", mem[16'h40], 32'hdead_beef);

    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("ldw_lat", 32'(lat), 32'd2);
    chk("ldw_data", rd, 32'hdead_beef);
    chk("ldw_addr", {16'b0, ea}, 32'h40);
    chk("ldw_ramen", 32'(en_cnt), 32'd1);

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h80ff_7f01);
    chk("st10_lat", 32'(lat), 32'd2);
    load("ldb_s13", 2'b00, 1'b1, 32'h13, 32'hffff_ff80);
    load("ldb_u12", 2'b00, 1'b0, 32'h12, 32'h0000_00ff);
    load("ldb_s10", 2'b00, 1'b1, 32'h10, 32'h0000_0001);
    load("ldb_s12", 2'b00, 1'b1, 32'h12, 32'hffff_ffff);
    load("ldh_s12", 2'b01, 1'b1, 32'h12, 32'hffff_80ff);
    load("ldh_u12", 2'b01, 1'b0, 32'h12, 32'h0000_80ff);
    load("ldh_s10", 2'b01, 1'b1, 32'h10, 32'h0000_7f01);

    reject("mis_w", 1'b0, 2'b10, 32'h102);
    reject("mis_h", 1'b0, 2'b01, 32'h101);
    reject("oor", 1'b0, 2'b10, 32'h0004_0000);
    reject("size3", 1'b0, 2'b11, 32'h100);

    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    chk("st20_lat", 32'(lat), 32'd2);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_abcd);
`ifdef LSU_RMW_EN
    chk("sth_lat", 32'(lat), 32'd3);
    chk("sth_err", {31'b0, er}, 32'd0);
    chk("sth_ramen", 32'(en_cnt), 32'd2);
    chk("sth_mem", mem[16'h8], 32'habcd_3344);
    load("ld20", 2'b10, 1'b0, 32'h20, 32'habcd_3344);
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0099);
    chk("stb_lat", 32'(lat), 32'd3);
    chk("stb_mem", mem[16'h8], 32'habcd_9944);
`else
    chk("sth_lat", 32'(lat), 32'd1);
    chk("sth_err", {31'b0, er}, 32'd1);
    chk("sth_ramen", 32'(en_cnt), 32'd0);
    chk("sth_mem", mem[16'h8], 32'h1122_3344);
    load("ld20", 2'b10, 1'b0, 32'h20, 32'h1122_3344);
`endif

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_ramen", {31'b0, ram_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ramen", {31'b0, ram_en}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_rspv", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", {31'b0, seen}, 32'd0);
    load("after_rst", 2'b10, 1'b0, 32'h100, 32'hdead_beef);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
